// File: rtl/spi_slv_pkg.sv
// Shared constants for the SPI responder register interface:
// command bytes and FSM state encoding.
package spi_slv_pkg;

  localparam logic [7:0] CMD_WR = 8'h80;
  localparam logic [7:0] CMD_RD = 8'h40;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

endpackage

// File: rtl/spi_slv_sync.sv
// Multi-flop synchronizer for one SPI pin plus a rise/fall edge detector
// on the synchronized level.
module spi_slv_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slv_regif.sv
// SPI mode-0 responder giving an external master byte-addressed access to a
// register file; all SPI pins are oversampled in the clk_i domain.
module spi_slv_regif
  import spi_slv_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              busy_o
);

  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

  logic sck_s, sck_rise, sck_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i),
    .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_csn_i),
    .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
  );
  spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic [2:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              re_dly_q, re_dly_d;
  logic              inc_q, inc_d;
  logic [2:0]        settle_q, settle_d;

  logic       settled, cs_assert, cs_deassert, byte_done, rd_active;
  logic [7:0] rx_next;

  // A csn fall produced only by the synchronizer refilling after reset is
  // not a real assertion; edges count once the pipeline holds live samples.
  assign settled     = (settle_q == SETTLE_MAX);
  assign cs_assert   = csn_fall & settled;
  assign cs_deassert = csn_rise;
  assign byte_done   = sck_rise & (bit_cnt_q == 3'd7);
  assign rx_next     = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    inc_d     = 1'b0;
    re_dly_d  = re_q;
    settle_d  = settled ? settle_q : settle_q + 3'd1;

    if (inc_q) addr_d = addr_q + ADDR_W'(1);
    if (sck_rise) begin
      rx_d      = rx_next;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // The fall right after a byte boundary must keep the freshly loaded MSB.
    if (sck_fall && (bit_cnt_q != 3'd0)) tx_d = {tx_q[6:0], 1'b0};
    if (re_dly_q && (state_q == ST_RDATA)) tx_d = reg_rdata_i;
    if (cs_assert) bit_cnt_d = 3'd0;

    if (cs_deassert) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      tx_d      = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE:   if (cs_assert) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (rx_next == CMD_WR) begin
              rd_d    = 1'b0;
              state_d = ST_ADDR;
            end else if (rx_next == CMD_RD) begin
              rd_d    = 1'b1;
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            addr_d = rx_next[ADDR_W-1:0];
            if (rd_q) begin
              re_d    = 1'b1;
              state_d = ST_RDATA;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            we_d    = 1'b1;
            wdata_d = rx_next;
            inc_d   = 1'b1;
          end
        end
        ST_RDATA: begin
          if (byte_done) begin
            addr_d = addr_q + ADDR_W'(1);
            re_d   = 1'b1;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      rd_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      re_dly_q  <= 1'b0;
      inc_q     <= 1'b0;
      settle_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      re_q      <= re_d;
      re_dly_q  <= re_dly_d;
      inc_q     <= inc_d;
      settle_q  <= settle_d;
    end
  end

  assign rd_active     = (state_q == ST_RDATA) & ~csn_s;
  assign spi_miso_oe_o = rd_active;
  assign spi_miso_o    = rd_active & tx_q[7];
  assign reg_addr_o    = addr_q;
  assign reg_wdata_o   = wdata_q;
  assign reg_we_o      = we_q;
  assign reg_re_o      = re_q;
  assign busy_o        = ~csn_s;

endmodule

// File: doc/spi_slv_regif.md
Name: spi_slv_regif

Overview:
- SPI mode-0 responder (slave) that gives an external SPI master byte-addressed access to an internal register file.
- Sits behind the pad ring, mirroring the SoC's SPI master controllers from the far end of the wire.
- Feeds the housekeeping/config register bank, i.e. the logic that drives the `spi_slv_ro_*` style status and config fields.
- All SPI pins are oversampled in the `clk_i` domain; there is no SCK-clocked logic.

Parameters:
- ADDR_W, 8, register address width. Must be 8, one address byte per transfer.
- SYNC_STAGES, 2, synchronizer depth on `spi_sck_i`, `spi_csn_i` and `spi_mosi_i`. Legal values are 2..3.

Ports:
- clk_i  in  1  system clock; must be ≥ 8× the SCK frequency.
- rst_i  in  1  synchronous, active-high reset.
- spi_sck_i  in  1  SPI clock from the external master, asynchronous to `clk_i`.
- spi_csn_i  in  1  chip select, active low.
- spi_mosi_i  in  1  serial data in, MSB first.
- spi_miso_o  out  1  serial data out, MSB first.
- spi_miso_oe_o  out  1  pad output enable for MISO, active high.
- reg_addr_o  out  ADDR_W  register address.
- reg_wdata_o  out  8  register write data.
- reg_we_o  out  1  write strobe, one-cycle pulse.
- reg_re_o  out  1  read strobe, one-cycle pulse.
- reg_rdata_i  in  8  read data, valid exactly 1 cycle after `reg_re_o`.
- busy_o  out  1  high while CS is asserted, after synchronization.

Behaviour:
- **Reset values.** `rst_i` is synchronous and active high. All outputs reset to 0. Synchronizer flops reset to idle bus levels (sck=0, csn=1, mosi=0). The FSM resets to IDLE, the bit counter to 0, and the address register to 0.
- **Synchronization and edges.**
  - Each SPI input passes through SYNC_STAGES flops, plus one more flop for edge detection.
  - A rising SCK edge (`sck_rise`) samples MOSI into the RX shift register, MSB first.
  - A falling SCK edge (`sck_fall`) advances the TX shift register.
  - CS assertion is the falling edge of the synchronized `csn`.
- **Bit counter.** 3 bits. Cleared on CS assertion, incremented on `sck_rise`. A byte completes on the `sck_rise` where the counter wraps 7→0.
- **FSM states:** IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE → CMD on CS assertion.
  - CMD, at byte completion:
    - 0x80 → ADDR, with the write flag set.
    - 0x40 → ADDR, with the read flag set.
    - Any other value → IGNORE.
  - ADDR, at byte completion: load the address register, then:
    - If the read flag is set, pulse `reg_re_o` in the next cycle and go to RDATA.
    - Otherwise go to WDATA.
  - WDATA, at each byte completion:
    - Cycle +1: pulse `reg_we_o`, with `reg_wdata_o` = received byte and `reg_addr_o` = current address.
    - Cycle +2: address increments.
  - RDATA:
    - One cycle after each `reg_re_o`, capture `reg_rdata_i` into the TX shift register.
    - `spi_miso_o` shows bit 7 immediately.
    - Each `sck_fall` shifts the next bit out.
    - At each byte completion: address increments, `reg_re_o` pulses for the new address, and the next byte is prefetched before the following `sck_fall`.
  - IGNORE: MISO stays 0 and no strobes fire. Leaves only on CS deassertion.
- **Address wrap.** The address wraps 0xFF → 0x00 in both streaming directions.
- **CS deassertion** (synchronized csn rises) in any state:
  - Return to IDLE next cycle.
  - Discard any partial byte; no `reg_we_o` is issued for it.
  - Clear the bit counter and the TX register.
  - An in-flight `reg_re_o` result may be captured but is never shifted out.
- **Read-prefetch side effect.** After a read burst of N bytes, N+1 `reg_re_o` strobes have occurred, because of the final prefetch. Registers must therefore have no read side effects.
- **MISO enable.** `spi_miso_oe_o` = 1 only in RDATA while CS is asserted. Elsewhere it is 0 and `spi_miso_o` = 0.
- **`busy_o`** = NOT synchronized `csn`.
- **Simultaneous events.** A CS deassertion in the same cycle as byte completion is not possible, since the edges come from separate bus events. If the synchronizer makes them coincident, deassertion wins and no strobe is issued.
- **Strobe exclusivity.** `reg_we_o` and `reg_re_o` are never high in the same cycle.

Decomposition:
- Shared package `spi_slv_pkg`:
  - Command constants `CMD_WR` = 8'h80 and `CMD_RD` = 8'h40.
  - FSM state encoding, localparam 3-bit.
- One sub-module, `spi_slv_sync`: parameterized SYNC_STAGES synchronizer plus rise/fall edge detector. It is instantiated 3×; only the SCK instance uses its edge outputs.
- The FSM, shifters and address counter stay in `spi_slv_regif`.

Test Plan:
- **Write burst.** SCK = clk/8. Send CS low, then 0x80, 0x10, 0xA5, 0x5A, then CS high. Expect two `reg_we_o` pulses: (0x10, 0xA5) then (0x11, 0x5A). MISO and OE stay 0 throughout.
- **Read burst.** Model registers with 0x20 = 0x3C and 0x21 = 0xC3. Send 0x40, 0x20, then clock 16 bits. Master captures 0x3C, 0xC3. OE is high only during the data phase. Exactly 3 `reg_re_o` pulses occur.
- **Address wrap.** Write 0x80, 0xFF, 0x11, 0x22. Expect writes (0xFF, 0x11) then (0x00, 0x22).
- **Bad command.** Send 0x33, 0x00, 0xFF. Expect no strobes, MISO = 0, OE = 0. A following valid write transaction on a new CS still works.
- **CS abort mid-byte.** Send 0x80, 0x05, then 4 bits of data, then CS high. Expect no `reg_we_o`, FSM back in IDLE, and the next transaction is decoded correctly from its first bit.
- **Reset mid-transfer.** Assert `rst_i` for 1 cycle during RDATA. All outputs are 0 the next cycle and the FSM is in IDLE. Bits clocked in before CS deasserts are ignored: the FSM stays IDLE, since CS-assertion detection requires a new falling edge.
